// File: rtl/ram_timing_ctrl.sv
// Word-addressed RAM with programmable wait states. Presents FREE/BUSY/ACCESS/ERROR
// status to the memory controller and completes each request after LAT BUSY cycles.
module ram_timing_ctrl #(
    parameter int unsigned LAT    = 2,
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned AW     = 14,
    parameter logic [31:0] POISON = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        memREN,
    input  logic        memWEN,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_ERR,
        REQ_VALID
    } req_class_t;

    logic              r_vld;
    logic [AW-1:0]     r_radr;
    logic              r_rwr;
    logic [3:0]        r_cnt;
    logic [31:0]       r_mem [DEPTH];

    logic [31:0]       w_word;
    logic [AW-1:0]     w_idx;
    logic              w_oob;
    logic              w_misaligned;
    req_class_t        w_class;
    logic              w_match;
    logic              w_cnt_done;
    logic              w_access;
    ramstate_t         w_state;

    assign w_word       = {2'b00, memaddr[31:2]};
    assign w_idx        = memaddr[AW+1:2];
    assign w_oob        = (w_word >= 32'(DEPTH));
    assign w_misaligned = (memaddr[1:0] != 2'b00);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_class = REQ_VALID;
        if ((memREN && memWEN) || w_misaligned || w_oob) begin
            w_class = REQ_ERR;
        end else if (!memREN && !memWEN) begin
            w_class = REQ_IDLE;
        end
    end

    // A request only continues counting if it is the same word and the same kind.
    assign w_match    = r_vld && (r_radr == w_idx) && (r_rwr == memWEN);
    assign w_cnt_done = (r_cnt == 4'(LAT));
    assign w_access   = nRST && (w_class == REQ_VALID) && w_match && w_cnt_done;

    always_comb begin
        w_state = BUSY;
        if (!nRST) begin
            w_state = FREE;
        end else begin
            case (w_class)
                REQ_IDLE:  w_state = FREE;
                REQ_ERR:   w_state = ERROR;
                default:   w_state = w_access ? ACCESS : BUSY;
            endcase
        end
    end

    assign ramstate = w_state;
    assign ramload  = (w_access && !r_rwr) ? r_mem[w_idx] : POISON;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_vld  <= 1'b0;
            r_radr <= '0;
            r_rwr  <= 1'b0;
            r_cnt  <= 4'd0;
        end else begin
            case (w_class)
                REQ_VALID: begin
                    if (!w_match) begin
                        r_vld  <= 1'b1;
                        r_radr <= w_idx;
                        r_rwr  <= memWEN;
                        r_cnt  <= 4'd1;
                    end else if (w_cnt_done) begin
                        r_vld <= 1'b0;
                        r_cnt <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_vld <= 1'b0;
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; w_access is already false while nRST is low,
    // so an access interrupted by reset never writes.
    always_ff @(posedge CLK) begin
        if (w_access && r_rwr) begin
            r_mem[w_idx] <= memstore;
        end
    end

endmodule
